fetch_unit: RTL and testbench

Program-counter and instruction-fetch stage sitting directly upstream of the instruction ROM. Drives the ROM address, registers the returned instruction word into an instruction register (IR) for the decoder, and handles start, stall, jump and branch redirects, and halt detection. One instruction per cycle when not stalled.

---
 rtl/fetch_unit.sv | 129 ++++++++++++
 tb/tb_fetch_unit.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// PC / instruction-fetch stage: drives the ROM address, registers the returned word into the IR,
// handles start, stall, jump/branch redirects and halt. Optional run-cycle counter: FETCH_CYCLE_COUNT_EN.
module fetch_unit #(
    parameter int IW = 16,
    parameter int DW = 9,
    parameter int OFFW = 6,
    parameter logic [IW-1:0] START_ADDR = '0,
    parameter logic [DW-1:0] HALT_INST = 9'h1FF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            stall,
    input  logic            jump_en,
    input  logic [IW-1:0]   jump_target,
    input  logic            branch_en,
    input  logic [OFFW-1:0] branch_off,
    output logic [IW-1:0]   inst_address,
    input  logic [DW-1:0]   inst_in,
    output logic [DW-1:0]   inst_out,
    output logic [IW-1:0]   inst_pc,
    output logic            inst_valid,
    output logic            done,
    output logic [15:0]     cycle_count
);

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    state_t          state_reg, state_next;
    logic [IW-1:0]   pc_reg, pc_next;
    logic [DW-1:0]   ir_reg, ir_next;
    logic [IW-1:0]   inst_pc_reg, inst_pc_next;
    logic            valid_reg, valid_next;
    logic [IW-1:0]   branch_target;

    // Branches are relative to the instruction currently in the IR, not the PC.
    assign branch_target = inst_pc_reg + {{(IW-OFFW){branch_off[OFFW-1]}}, branch_off};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            pc_reg      <= '0;
            ir_reg      <= '0;
            inst_pc_reg <= '0;
            valid_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            ir_reg      <= ir_next;
            inst_pc_reg <= inst_pc_next;
            valid_reg   <= valid_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        ir_next      = ir_reg;
        inst_pc_next = inst_pc_reg;
        valid_next   = valid_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    pc_next    = START_ADDR;
                    valid_next = 1'b0;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (jump_en) begin
                    pc_next    = jump_target;
                    valid_next = 1'b0;
                end else if (branch_en) begin
                    pc_next    = branch_target;
                    valid_next = 1'b0;
                end else if (!stall) begin
                    ir_next      = inst_in;
                    inst_pc_next = pc_reg;
                    valid_next   = 1'b1;
                    // The halt word is latched as a valid instruction; the PC parks on it.
                    if (inst_in == HALT_INST) begin
                        state_next = HALT;
                    end else begin
                        pc_next = pc_reg + IW'(1);
                    end
                end
            end
            HALT: begin
                valid_next = 1'b0;
                if (start) begin
                    pc_next    = START_ADDR;
                    state_next = RUN;
                end
            end
            default: begin
                state_next = IDLE;
                valid_next = 1'b0;
            end
        endcase
    end

    assign inst_address = pc_reg;
    assign inst_out     = ir_reg;
    assign inst_pc      = inst_pc_reg;
    assign inst_valid   = valid_reg;
    assign done         = (state_reg == HALT);

`ifdef FETCH_CYCLE_COUNT_EN
    logic [15:0] cnt_reg;
    logic        start_taken;

    assign start_taken = start && ((state_reg == IDLE) || (state_reg == HALT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (start_taken) begin
            cnt_reg <= '0;
        end else if ((state_reg == RUN) && (cnt_reg != 16'hFFFF)) begin
            cnt_reg <= cnt_reg + 16'd1;
        end
    end

    assign cycle_count = cnt_reg;
`else
    assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, hand-written redirect/wrap/reset
// sequences, and randomized traffic checked against a behavioural model.
module tb_fetch_unit;

`ifdef FETCH_CYCLE_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stall = 1'b0;
    logic        jump_en = 1'b0;
    logic [15:0] jump_target = '0;
    logic        branch_en = 1'b0;
    logic [5:0]  branch_off = '0;
    logic [15:0] inst_address;
    logic [8:0]  inst_in;
    logic [8:0]  inst_out;
    logic [15:0] inst_pc;
    logic        inst_valid;
    logic        done;
    logic [15:0] cycle_count;

    logic [8:0] rom [0:65535];
    assign inst_in = rom[inst_address];

    fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
        .jump_en(jump_en), .jump_target(jump_target),
        .branch_en(branch_en), .branch_off(branch_off),
        .inst_address(inst_address), .inst_in(inst_in),
        .inst_out(inst_out), .inst_pc(inst_pc), .inst_valid(inst_valid),
        .done(done), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Behavioural reference: mode 0 = idle, 1 = running, 2 = halted.
    int          m_mode;
    logic [15:0] m_pc, m_ipc;
    logic [8:0]  m_ir;
    logic        m_valid;
    int          m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_pc = '0; m_ipc = '0; m_ir = '0; m_valid = 1'b0; m_cnt = 0;
    endtask

    task automatic model_step();
        int t;
        if (m_mode == 1) begin
            if (CNT_EN && m_cnt < 65535) m_cnt = m_cnt + 1;
            if (jump_en) begin
                m_pc = jump_target; m_valid = 1'b0;
            end else if (branch_en) begin
                t = int'(m_ipc) + int'($signed(branch_off));
                m_pc = 16'(t & 32'hFFFF); m_valid = 1'b0;
            end else if (!stall) begin
                m_ir = rom[m_pc]; m_ipc = m_pc; m_valid = 1'b1;
                if (m_ir == 9'h1FF) m_mode = 2;
                else m_pc = 16'((int'(m_pc) + 1) % 65536);
            end
        end else begin
            if (m_mode == 2) m_valid = 1'b0;
            if (start) begin
                m_mode = 1; m_pc = 16'h0000; m_valid = 1'b0; m_cnt = 0;
            end
        end
    endtask

    task automatic compare_model(input string tag);
        check({tag, ".addr"}, 32'(inst_address), 32'(m_pc));
        check({tag, ".out"}, 32'(inst_out), 32'(m_ir));
        check({tag, ".pc"}, 32'(inst_pc), 32'(m_ipc));
        check({tag, ".valid"}, 32'(inst_valid), 32'(m_valid));
        check({tag, ".done"}, 32'(done), 32'(m_mode == 2));
        check({tag, ".cnt"}, 32'(cycle_count), 32'(m_cnt));
    endtask

    task automatic drive(input logic s, input logic st, input logic j, input logic [15:0] jt,
                         input logic b, input logic [5:0] bo);
        start = s; stall = st; jump_en = j; jump_target = jt; branch_en = b; branch_off = bo;
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        compare_model(tag);
        $display("%s addr=%h out=%h pc=%h v=%b done=%b cnt=%0d",
                 tag, inst_address, inst_out, inst_pc, inst_valid, done, cycle_count);
    endtask

    typedef struct {
        logic        start, stall, jump_en;
        logic [15:0] jump_target;
        logic        branch_en;
        logic [5:0]  branch_off;
        logic [15:0] exp_addr;
        logic [8:0]  exp_out;
        logic        exp_valid, exp_done;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs [10];
    logic [8:0] plan_out [4];

    initial begin
        // start, stall, jump, target, branch, off | addr, out, valid, done, cnt
        vecs[0] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 6'd0, 16'd0, 9'h000, 1'b0, 1'b0, 16'd0};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 6'd0, 16'd1, 9'h001, 1'b1, 1'b0, 16'd1};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 6'd0, 16'd2, 9'h002, 1'b1, 1'b0, 16'd2};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 6'd0, 16'd2, 9'h002, 1'b1, 1'b0, 16'd3};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 6'd0, 16'd2, 9'h002, 1'b1, 1'b0, 16'd4};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 6'd0, 16'd2, 9'h002, 1'b1, 1'b0, 16'd5};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 6'd0, 16'd3, 9'h003, 1'b1, 1'b0, 16'd6};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 6'd0, 16'd3, 9'h1FF, 1'b1, 1'b1, 16'd7};
        vecs[8] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 6'd0, 16'd3, 9'h1FF, 1'b0, 1'b1, 16'd7};
        vecs[9] = '{1'b0, 1'b0, 1'b1, 16'h0040, 1'b1, 6'd1, 16'd3, 9'h1FF, 1'b0, 1'b1, 16'd7};
        plan_out[0] = 9'h001; plan_out[1] = 9'h002; plan_out[2] = 9'h003; plan_out[3] = 9'h1FF;

        for (int i = 0; i < 65536; i++) rom[i] = 9'($urandom_range(0, 510));
        rom[0] = 9'h001; rom[1] = 9'h002; rom[2] = 9'h003; rom[3] = 9'h1FF;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset.addr", 32'(inst_address), 32'h0);
        check("reset.out", 32'(inst_out), 32'h0);
        check("reset.pc", 32'(inst_pc), 32'h0);
        check("reset.valid", 32'(inst_valid), 32'h0);
        check("reset.done", 32'(done), 32'h0);
        check("reset.cnt", 32'(cycle_count), 32'h0);
        rst_n = 1'b1;
        tick("idle");

        // Vector table: fetch, 3-cycle stall, halt, redirect ignored in halt
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].start, vecs[i].stall, vecs[i].jump_en, vecs[i].jump_target,
                  vecs[i].branch_en, vecs[i].branch_off);
            tick($sformatf("vec%0d", i));
            check($sformatf("vec%0d.addr", i), 32'(inst_address), 32'(vecs[i].exp_addr));
            check($sformatf("vec%0d.out", i), 32'(inst_out), 32'(vecs[i].exp_out));
            check($sformatf("vec%0d.valid", i), 32'(inst_valid), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d.done", i), 32'(done), 32'(vecs[i].exp_done));
            check($sformatf("vec%0d.cnt", i), 32'(cycle_count), CNT_EN ? 32'(vecs[i].exp_cnt) : 32'h0);
        end

        // Restart from HALT: clean 4-word program, counter restarts
        drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 6'd0);
        tick("restart");
        check("restart.done", 32'(done), 32'h0);
        check("restart.addr", 32'(inst_address), 32'h0);
        check("restart.cnt", 32'(cycle_count), 32'h0);
        drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 6'd0);
        for (int i = 0; i < 4; i++) begin
            tick($sformatf("plan%0d", i));
            check($sformatf("plan%0d.out", i), 32'(inst_out), 32'(plan_out[i]));
            check($sformatf("plan%0d.valid", i), 32'(inst_valid), 32'h1);
        end
        check("plan.done", 32'(done), 32'h1);
        check("plan.cnt", 32'(cycle_count), CNT_EN ? 32'd4 : 32'd0);

        // Branch -2 from inst_pc 5
        rom[3] = 9'h0AA;
        drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 6'd0);
        tick("br.start");
        drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 6'd0);
        for (int i = 0; i < 6; i++) tick("br.run");
        check("br.ipc5", 32'(inst_pc), 32'd5);
        drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 6'b111110);
        tick("br.take");
        check("br.addr", 32'(inst_address), 32'd3);
        check("br.bubble", 32'(inst_valid), 32'h0);
        drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 6'd0);
        tick("br.target");
        check("br.out", 32'(inst_out), 32'h0AA);
        check("br.ipc", 32'(inst_pc), 32'd3);
        check("br.valid", 32'(inst_valid), 32'h1);

        // Jump + branch + stall together: jump wins
        drive(1'b0, 1'b1, 1'b1, 16'h0040, 1'b1, 6'd1);
        tick("jmp.take");
        check("jmp.addr", 32'(inst_address), 32'h40);
        check("jmp.bubble", 32'(inst_valid), 32'h0);
        drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 6'd0);
        rom[16'h40] = 9'h055;
        tick("jmp.target");
        check("jmp.ipc", 32'(inst_pc), 32'h40);
        check("jmp.out", 32'(inst_out), 32'h055);

        // PC wrap at 0xFFFF
        rom[16'hFFFF] = 9'h011; rom[0] = 9'h022;
        drive(1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b0, 6'd0);
        tick("wrap.jump");
        drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 6'd0);
        tick("wrap.top");
        check("wrap.addr0", 32'(inst_address), 32'h0);
        check("wrap.ipc", 32'(inst_pc), 32'hFFFF);
        tick("wrap.next");
        check("wrap.out0", 32'(inst_out), 32'h022);
        check("wrap.ipc0", 32'(inst_pc), 32'h0);

        // Asynchronous reset mid-run
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_model("areset");
        check("areset.addr", 32'(inst_address), 32'h0);
        check("areset.valid", 32'(inst_valid), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 6'd0);
        tick("post.start");
        drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 6'd0);
        tick("post.fetch");
        check("post.out", 32'(inst_out), 32'h022);
        check("post.valid", 32'(inst_valid), 32'h1);

        // Randomized traffic against the model
        for (int i = 0; i < 65536; i++)
            rom[i] = ($urandom_range(0, 63) == 0) ? 9'h1FF : 9'($urandom_range(0, 510));
        for (int i = 0; i < 1500; i++) begin
            drive($urandom_range(0, 19) == 0, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 15) == 0, 16'($urandom),
                  $urandom_range(0, 9) == 0, 6'($urandom));
            tick($sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
